// File: rtl/sc_levelseq_pkg.sv
// Shared state encodings and field widths for the level sequencer.
package sc_levelseq_pkg;

    localparam int LEVEL_W = 2;
    localparam int LIVES_W = 2;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_PLAY     = 3'd2,
        ST_ADVANCE  = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } state_t;

    // Gameplay is frozen in every state except PLAY.
    function automatic logic is_frozen(input state_t s);
        return s != ST_PLAY;
    endfunction

endpackage

// File: rtl/sc_hold_timer.sv
// Loadable down-counter that times the level banner; o_done is high at zero.
module sc_hold_timer #(
    parameter int W = 26
) (
    input  logic         SC_COUNTER_CLOCK_50,
    input  logic         SC_COUNTER_RESET_InHigh,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge SC_COUNTER_CLOCK_50 or posedge SC_COUNTER_RESET_InHigh) begin
        if (SC_COUNTER_RESET_InHigh)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && (r_count != '0))
            r_count <= r_count - W'(1);
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger level/lives sequencer: banner hold, level advance, win and game-over.
// Define SC_LEVELSEQ_LIVES_EN to enable the lives counter; otherwise any crash ends the game.
module sc_level_sequencer
    import sc_levelseq_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000,
    parameter int MAX_LEVEL   = 3,
    parameter int LIVES_INIT  = 3
) (
    input  logic               SC_COUNTER_CLOCK_50,
    input  logic               SC_COUNTER_RESET_InHigh,
    input  logic               start_i,
    input  logic               goal_i,
    input  logic               crash_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic               level_load_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic               hold_o,
    output logic               gameover_o,
    output logic               win_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int                 TMR_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);

`ifdef SC_LEVELSEQ_LIVES_EN
    localparam bit                 LIVES_EN    = 1'b1;
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);
`else
    // Lives register never leaves zero, so lives_o is effectively tied low.
    localparam bit                 LIVES_EN    = 1'b0;
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT) & '0;
`endif

    state_t               r_state;
    logic [LEVEL_W-1:0]   r_level;
    logic [LIVES_W-1:0]   r_lives;
    logic                 r_load;
    logic                 r_hold;
    logic                 r_gameover;
    logic                 r_win;

    state_t               w_state_nxt;
    logic [LEVEL_W-1:0]   w_level_nxt;
    logic [LIVES_W-1:0]   w_lives_nxt;
    logic                 w_load_nxt;
    logic                 w_tmr_load;
    logic                 w_tmr_en;
    logic                 w_tmr_done;

    assign w_tmr_en = (r_state == ST_HOLD);

    sc_hold_timer #(
        .W (TMR_W)
    ) u_hold_timer (
        .SC_COUNTER_CLOCK_50     (SC_COUNTER_CLOCK_50),
        .SC_COUNTER_RESET_InHigh (SC_COUNTER_RESET_InHigh),
        .i_load                  (w_tmr_load),
        .i_load_val              (TMR_LOAD),
        .i_en                    (w_tmr_en),
        .o_done                  (w_tmr_done)
    );

    // Timer is reloaded on every edge that enters HOLD so the dwell is exact.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_lives_nxt = r_lives;
        w_load_nxt  = 1'b0;
        w_tmr_load  = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAMEOVER, ST_WIN: begin
                if (start_i) begin
                    w_state_nxt = ST_HOLD;
                    w_level_nxt = '0;
                    w_lives_nxt = LIVES_START;
                    w_load_nxt  = 1'b1;
                    w_tmr_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_tmr_done)
                    w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (crash_i) begin
                    if (!LIVES_EN || (r_lives <= LIVES_W'(1))) begin
                        w_state_nxt = ST_GAMEOVER;
                        w_lives_nxt = '0;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_lives_nxt = r_lives - LIVES_W'(1);
                        w_tmr_load  = 1'b1;
                    end
                end else if (goal_i) begin
                    if (r_level < LVL_MAX) begin
                        w_state_nxt = ST_ADVANCE;
                        w_level_nxt = r_level + LEVEL_W'(1);
                        w_load_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WIN;
                    end
                end
            end
            ST_ADVANCE: begin
                w_state_nxt = ST_HOLD;
                w_tmr_load  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_COUNTER_CLOCK_50 or posedge SC_COUNTER_RESET_InHigh) begin
        if (SC_COUNTER_RESET_InHigh) begin
            r_state    <= ST_IDLE;
            r_level    <= '0;
            r_lives    <= '0;
            r_load     <= 1'b0;
            r_hold     <= 1'b1;
            r_gameover <= 1'b0;
            r_win      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_lives    <= w_lives_nxt;
            r_load     <= w_load_nxt;
            r_hold     <= is_frozen(w_state_nxt);
            r_gameover <= (w_state_nxt == ST_GAMEOVER);
            r_win      <= (w_state_nxt == ST_WIN);
        end
    end

    assign level_o      = r_level;
    assign lives_o      = r_lives;
    assign level_load_o = r_load;
    assign hold_o       = r_hold;
    assign gameover_o   = r_gameover;
    assign win_o        = r_win;
    assign state_o      = r_state;

endmodule
